// File: rtl/alu_mult_seq.sv
// alu_mult_seq: multi-cycle shift-and-add multiplier (signed or unsigned).
// It has no adder of its own. It drives the shared execute-stage ALU while busy
// and consumes the ALU result and carry in the same cycle.
module alu_mult_seq #(
    parameter int SIZE = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            sign,
    input  logic [SIZE-1:0] op_a,
    input  logic [SIZE-1:0] op_b,
    output logic            busy,
    output logic            done,
    output logic [SIZE-1:0] hi,
    output logic [SIZE-1:0] lo,
    output logic [3:0]      alu_op,
    output logic [SIZE-1:0] alu_a,
    output logic [SIZE-1:0] alu_b,
    input  logic [SIZE-1:0] alu_out,
    input  logic            alu_carry
);

    localparam int CW = (SIZE > 1) ? $clog2(SIZE) : 1;

    localparam logic [3:0] OP_NOP = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;

    typedef enum logic [2:0] {
        st_idle,
        st_nega,
        st_negb,
        st_iter,
        st_fixlo,
        st_fixhi,
        st_done
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [SIZE-1:0] mcand;     // multiplicand (magnitude after NEGA in signed mode)
    logic [CW-1:0]   cnt;       // remaining ITER steps minus one
    logic            neg;       // final product must be negated
    logic            sgn;       // operation is signed
    logic            lo_zero;   // low word was zero before the final negation

    assign busy = (state != st_idle) && (state != st_done);
    assign done = (state == st_done);

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values, independent of the order of always blocks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= st_idle;
        else     state <= state_nx;
    end

    // Next-state decode and ALU operand/opcode selection for each step.
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_nx = state;
        alu_op   = OP_NOP;
        alu_a    = '0;
        alu_b    = '0;
        case (state)
            st_idle: begin
                if (start) state_nx = sign ? st_nega : st_iter;
            end
            st_nega: begin
                // |a|: 0 - a when negative, otherwise a pass-through add
                if (mcand[SIZE-1]) begin
                    alu_op = OP_SUB;
                    alu_b  = mcand;
                end else begin
                    alu_op = OP_ADD;
                    alu_a  = mcand;
                end
                state_nx = st_negb;
            end
            st_negb: begin
                // b was parked in lo at accept time
                if (lo[SIZE-1]) begin
                    alu_op = OP_SUB;
                    alu_b  = lo;
                end else begin
                    alu_op = OP_ADD;
                    alu_a  = lo;
                end
                state_nx = st_iter;
            end
            st_iter: begin
                alu_op = OP_ADD;
                alu_a  = hi;
                alu_b  = lo[0] ? mcand : '0;
                if (cnt == '0) state_nx = sgn ? st_fixlo : st_done;
            end
            st_fixlo: begin
                if (neg) begin
                    alu_op = OP_SUB;
                    alu_b  = lo;
                end else begin
                    alu_op = OP_ADD;
                    alu_a  = lo;
                end
                state_nx = st_fixhi;
            end
            st_fixhi: begin
                // ~hi plus the carry out of the low-word negation (only when lo was 0)
                alu_op = OP_ADD;
                if (neg) begin
                    alu_a = ~hi;
                    alu_b = {{(SIZE-1){1'b0}}, lo_zero};
                end else begin
                    alu_a = hi;
                end
                state_nx = st_done;
            end
            st_done: begin
                state_nx = st_idle;
            end
            default: begin
                state_nx = st_idle;
            end
        endcase
    end

    // Datapath: operand capture, magnitude fix-up, shift-and-add and product negation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand   <= '0;
            cnt     <= '0;
            neg     <= 1'b0;
            sgn     <= 1'b0;
            lo_zero <= 1'b0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            case (state)
                st_idle: begin
                    if (start) begin
                        mcand <= op_a;
                        lo    <= op_b;
                        hi    <= '0;
                        cnt   <= CW'(SIZE - 1);
                        sgn   <= sign;
                        neg   <= sign & (op_a[SIZE-1] ^ op_b[SIZE-1]);
                    end
                end
                st_nega: begin
                    mcand <= alu_out;
                end
                st_negb: begin
                    lo  <= alu_out;
                    hi  <= '0;
                    cnt <= CW'(SIZE - 1);
                end
                st_iter: begin
                    // {carry, sum, lo} shifted right by one
                    hi <= {alu_carry, alu_out[SIZE-1:1]};
                    lo <= {alu_out[0], lo[SIZE-1:1]};
                    if (cnt != '0) cnt <= cnt - CW'(1);
                end
                st_fixlo: begin
                    lo      <= alu_out;
                    lo_zero <= (lo == '0);
                end
                st_fixhi: begin
                    hi <= alu_out;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mult_seq.sv
// Self-checking bench for alu_mult_seq: directed cases, handshake, mid-operation
// reset and random operands, checked against a plain-arithmetic product model.
// The bench also plays the role of the shared combinational ALU.
module tb_alu_mult_seq;

    localparam int SIZE = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic            sign;
    logic [SIZE-1:0] op_a;
    logic [SIZE-1:0] op_b;
    logic            busy;
    logic            done;
    logic [SIZE-1:0] hi;
    logic [SIZE-1:0] lo;
    logic [3:0]      alu_op;
    logic [SIZE-1:0] alu_a;
    logic [SIZE-1:0] alu_b;
    logic [SIZE-1:0] alu_out;
    logic            alu_carry;

    int total = 0;
    int bad   = 0;

    alu_mult_seq #(.SIZE(SIZE)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .sign      (sign),
        .op_a      (op_a),
        .op_b      (op_b),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo),
        .alu_op    (alu_op),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_out   (alu_out),
        .alu_carry (alu_carry)
    );

    always #5 clk = ~clk;

    // Shared ALU model: ADD reports carry-out, SUB reports signed overflow.
    always_comb begin
        alu_out   = '0;
        alu_carry = 1'b0;
        case (alu_op)
            4'b0010: {alu_carry, alu_out} = {1'b0, alu_a} + {1'b0, alu_b};
            4'b0110: begin
                alu_out   = alu_a - alu_b;
                alu_carry = (alu_a[SIZE-1] != alu_b[SIZE-1]) && (alu_out[SIZE-1] != alu_a[SIZE-1]);
            end
            default: begin
            end
        endcase
    end

    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input logic s);
        longint sa;
        longint sb;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return 64'(sa * sb);
        end
        return {32'b0, a} * {32'b0, b};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One multiply with a single-cycle start pulse; checks latency, busy window,
    // single done pulse, product, idle ALU opcode at done and hold after done.
    task automatic run_mult(input string tag, input logic [31:0] a, input logic [31:0] b, input logic s);
        int          lat;
        int          done_cyc;
        int          busy_err;
        int          npulse;
        logic [63:0] exp;
        logic [63:0] got;
        logic [3:0]  op_at_done;
        lat        = s ? SIZE + 5 : SIZE + 1;
        done_cyc   = -1;
        busy_err   = 0;
        npulse     = 0;
        exp        = ref_mul(a, b, s);
        got        = 'x;
        op_at_done = 'x;
        @(negedge clk);
        start = 1'b1;
        op_a  = a;
        op_b  = b;
        sign  = s;
        for (int k = 1; k <= lat + 3; k++) begin
            @(negedge clk);
            if (done) begin
                npulse++;
                if (done_cyc < 0) begin
                    done_cyc   = k;
                    got        = {hi, lo};
                    op_at_done = alu_op;
                end
            end
            if ((k < lat) != busy) busy_err++;
            if (k == 1) start = 1'b0;
            op_a = $urandom;
            op_b = $urandom;
            sign = 1'($urandom_range(0, 1));
        end
        check($sformatf("%s.latency", tag), 64'(done_cyc), 64'(lat));
        check($sformatf("%s.busy", tag), 64'(busy_err), 64'd0);
        check($sformatf("%s.pulses", tag), 64'(npulse), 64'd1);
        check($sformatf("%s.product", tag), got, exp);
        check($sformatf("%s.aluop_done", tag), 64'(op_at_done), 64'd0);
        check($sformatf("%s.hold", tag), {hi, lo}, exp);
    endtask

    initial begin
        int          npulse;
        int          op_err;
        int          pulse_cyc[$];
        logic [63:0] got1;
        logic [63:0] got2;
        logic        busy34;
        logic        busy35;
        logic [31:0] a1;
        logic [31:0] b1;
        logic [31:0] a2;
        logic [31:0] b2;

        // Reset state
        rst   = 1'b1;
        start = 1'b0;
        sign  = 1'b0;
        op_a  = '0;
        op_b  = '0;
        @(negedge clk);
        @(negedge clk);
        check("reset.busy", 64'(busy), 64'd0);
        check("reset.done", 64'(done), 64'd0);
        check("reset.hilo", {hi, lo}, 64'd0);
        check("reset.aluop", 64'(alu_op), 64'd0);
        rst = 1'b0;

        // Reset in the middle of an unsigned 5*7
        @(negedge clk);
        start = 1'b1;
        op_a  = 32'd5;
        op_b  = 32'd7;
        sign  = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
        end
        rst = 1'b1;
        #1;
        check("midrst.hilo", {hi, lo}, 64'd0);
        check("midrst.busy", 64'(busy), 64'd0);
        check("midrst.done", 64'(done), 64'd0);
        @(negedge clk);
        rst    = 1'b0;
        npulse = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done) npulse++;
        end
        check("midrst.no_done", 64'(npulse), 64'd0);
        run_mult("post_rst_5x7", 32'd5, 32'd7, 1'b0);

        // Directed corner cases
        run_mult("umax", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_mult("s_mixed", 32'hFFFF_FFFD, 32'd7, 1'b1);
        run_mult("s_min_min", 32'h8000_0000, 32'h8000_0000, 1'b1);
        run_mult("s_m1_m1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        run_mult("s_neg_zero", 32'hFFFF_FFFF, 32'd0, 1'b1);
        run_mult("s_m1_x10000", 32'hFFFF_FFFF, 32'h0001_0000, 1'b1);
        run_mult("u_zero", 32'd0, 32'd0, 1'b0);
        run_mult("s_pos_neg", 32'd12345, 32'hFFFF_FF00, 1'b1);

        // Handshake: start held high; one accept per IDLE visit
        a1 = $urandom;
        b1 = $urandom;
        a2 = $urandom;
        b2 = $urandom;
        op_err = 0;
        got1   = 'x;
        got2   = 'x;
        busy34 = 1'bx;
        busy35 = 1'bx;
        @(negedge clk);
        start = 1'b1;
        sign  = 1'b0;
        op_a  = a1;
        op_b  = b1;
        for (int k = 1; k <= 70; k++) begin
            @(negedge clk);
            if (done) begin
                pulse_cyc.push_back(k);
                if (pulse_cyc.size() == 1) got1 = {hi, lo};
                if (pulse_cyc.size() == 2) got2 = {hi, lo};
                if (alu_op != 4'b0000) op_err++;
            end
            if (!busy && !done && alu_op != 4'b0000) op_err++;
            if (k == 34) busy34 = busy;
            if (k == 35) busy35 = busy;
            if (k == 33) begin
                op_a = a2;
                op_b = b2;
            end else if (k == 67) begin
                start = 1'b0;
            end else if (k != 34) begin
                op_a = $urandom;
                op_b = $urandom;
            end
        end
        check("hs.pulses", 64'(pulse_cyc.size()), 64'd2);
        if (pulse_cyc.size() == 2) begin
            check("hs.first_cyc", 64'(pulse_cyc[0]), 64'd33);
            check("hs.second_cyc", 64'(pulse_cyc[1]), 64'd67);
        end
        check("hs.product1", got1, ref_mul(a1, b1, 1'b0));
        check("hs.product2", got2, ref_mul(a2, b2, 1'b0));
        check("hs.aluop_idle", 64'(op_err), 64'd0);
        check("hs.busy_idle", 64'(busy34), 64'd0);
        check("hs.busy_next", 64'(busy35), 64'd1);

        // Random operands, random signedness
        for (int i = 0; i < 12; i++) begin
            logic [31:0] ra;
            logic [31:0] rb;
            logic        rs;
            ra = $urandom;
            rb = $urandom;
            rs = 1'($urandom_range(0, 1));
            if (i % 4 == 1) ra = 32'h8000_0000;
            if (i % 4 == 2) rb = 32'(-int'($urandom_range(1, 9)));
            run_mult($sformatf("rand%0d", i), ra, rb, rs);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
